serial_adder: RTL and testbench

- Bit-serial N-bit adder: the additive counterpart of the team's half-subtractor datapath.
- Processes operands LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Start/busy/done handshake; used where area matters more than latency (e.g. accumulate paths in the arithmetic test designs).

---
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell plus carry flop.
// Operands are processed LSB-first, one bit per clock.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - request, accepted in IDLE or DONE
//   A, B          - operands, captured on the accepting edge
//   Sum, Cout     - registered result (A+B mod 2^WIDTH) and carry out of the MSB
//   busy          - high while bits are being shifted
//   done          - one-cycle pulse when Sum/Cout hold the final result
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               s_bit;
    logic               c_next;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, full-adder cell and shift logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_bit   = a_q[0] ^ b_q[0] ^ carry_q;
        c_next  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

        case (state_q)
            S_IDLE, S_DONE: begin
                // Sum/Cout stay untouched on acceptance; they change on the first SHIFT edge
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                // New sum bit enters at the MSB; after WIDTH shifts it lands in place
                sum_d   = (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
                carry_d = c_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    cout_d  = c_next;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered copies of the upcoming state
        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Sum;
    logic       Cout;
    logic       busy;
    logic       done;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] sum1;
    logic       cout1;
    logic       busy1;
    logic       done1;

    int total = 0;
    int bad   = 0;

    // expected {Cout, Sum} per accepted operation, oldest first
    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Sum   (Sum),
        .Cout  (Cout),
        .busy  (busy),
        .done  (done)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .A     (a1),
        .B     (b1),
        .Sum   (sum1),
        .Cout  (cout1),
        .busy  (busy1),
        .done  (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("sum", 32'(Sum), 32'(e[7:0]));
                check("cout", 32'(Cout), 32'(e[8]));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic wait_done(output int cyc);
        bit seen;
        seen = 0;
        cyc  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Issue one operation; glitch>0 pulses start with FF/FF before edge T(glitch+1)
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] exp, input int glitch);
        int  cyc;
        int  busy_cnt;
        bit  seen;
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        busy_cnt = 1;
        cyc  = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (glitch != 0 && cyc == glitch) begin
                start = 1'b1;
                A = 8'hFF;
                B = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(cyc), 32'd8);
        check("busy_cycles", 32'(busy_cnt), 32'd8);
        @(negedge clk);
        check("done_low_after", 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        int done_cnt;
        rst_n  = 1'b0;
        start  = 1'b0;
        A      = '0;
        B      = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;

        repeat (2) @(negedge clk);
        check("rst_sum", 32'(Sum), 32'd0);
        check("rst_cout", 32'(Cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h3C, 8'h05, {1'b0, 8'h41}, 0);
        run_op(8'hFF, 8'h01, {1'b1, 8'h00}, 0);
        run_op(8'h00, 8'h00, {1'b0, 8'h00}, 0);
        run_op(8'h10, 8'h20, {1'b0, 8'h30}, 2);
        run_op(8'hFF, 8'hFF, {1'b1, 8'hFE}, 0);

        // Asynchronous abort mid-operation
        @(negedge clk);
        start = 1'b1;
        A = 8'hFF;
        B = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sum", 32'(Sum), 32'd0);
        check("abort_cout", 32'(Cout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_done_after_abort", 32'(done_cnt), 32'd0);
        check("idle_after_abort", 32'(busy), 32'd0);

        // Back-to-back: start held through the DONE cycle
        @(negedge clk);
        start = 1'b1;
        A = 8'h3C;
        B = 8'h05;
        exp_q.push_back({1'b0, 8'h41});
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("b2b_first_latency", 32'(cyc), 32'd8);
        start = 1'b1;
        A = 8'h80;
        B = 8'h80;
        exp_q.push_back({1'b1, 8'h00});
        @(negedge clk);
        start = 1'b0;
        check("b2b_sum_held", 32'(Sum), 32'h41);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(cyc);
        check("b2b_spacing", 32'(cyc + 1), 32'd9);
        @(negedge clk);

        // WIDTH=1 instance
        start1 = 1'b1;
        a1 = 1'b1;
        b1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("w1_busy", 32'(busy1), 32'd1);
        check("w1_not_done_yet", 32'(done1), 32'd0);
        @(negedge clk);
        check("w1_done", 32'(done1), 32'd1);
        check("w1_sum_11", 32'(sum1), 32'd0);
        check("w1_cout_11", 32'(cout1), 32'd1);
        check("w1_busy_at_done", 32'(busy1), 32'd0);
        start1 = 1'b1;
        a1 = 1'b1;
        b1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        check("w1_done_2", 32'(done1), 32'd1);
        check("w1_sum_10", 32'(sum1), 32'd1);
        check("w1_cout_10", 32'(cout1), 32'd0);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
